fp_issue_ctrl: RTL

//  Parametrised issue/completion controller between FP decoder and FPU datapath. Supports up to MAX_INFLIGHT

---
 rtl/fp_issue_pkg.sv | 33 +++
 rtl/fp_tag_table.sv | 60 ++++++
 rtl/fp_issue_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fp_issue_pkg.sv
// Shared types for the FP issue/completion controller: slot record, flag vector
// and the bit positions of the individual IEEE exception flags.
package fp_issue_pkg;

  localparam int REG_AW = 5;   // FP and integer register address width
  localparam int FLAG_W = 5;   // {NV,DZ,OF,UF,NX}

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  typedef logic [FLAG_W-1:0] fflags_t;

  // One in-flight FP operation, indexed by its FPU tag.
  typedef struct packed {
    logic              valid;
    logic              fp_wr;
    logic              int_wr;
    logic [REG_AW-1:0] rd;
  } slot_t;

  // Sticky flag update; a clear in the same cycle wins over the old value
  // but not over the status that arrives with it.
  function automatic fflags_t fflags_merge(input fflags_t cur, input fflags_t status,
                                           input logic acc, input logic clr);
    fflags_t base;
    base = clr ? '0 : cur;
    return acc ? (base | status) : base;
  endfunction

endpackage

// File: rtl/fp_tag_table.sv
// Table of in-flight FP ops. The slot index doubles as the FPU tag. New ops get
// the lowest free slot, judged from the registered valid bits, so a slot freed
// this cycle only becomes allocatable on the next one.
module fp_tag_table
  import fp_issue_pkg::*;
#(
  parameter int  MAX_INFLIGHT = 4,
  localparam int TAG_W        = $clog2(MAX_INFLIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic              alloc_fp_wr_i,
  input  logic              alloc_int_wr_i,
  input  logic [REG_AW-1:0] alloc_rd_i,
  input  logic              free_i,
  input  logic [TAG_W-1:0]  free_tag_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output slot_t             lookup_slot_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  output logic              full_o,
  output logic              any_valid_o
);

  slot_t                   slots_q [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] valid_vec;

  for (genvar gi = 0; gi < MAX_INFLIGHT; gi++) begin : gen_valid
    assign valid_vec[gi] = slots_q[gi].valid;
  end

  // Lowest-index free slot: scan downwards so the last hit is the smallest index.
  always_comb begin
    alloc_tag_o = '0;
    for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_tag_o = TAG_W'(i);
    end
  end

  assign full_o        = &valid_vec;
  assign any_valid_o   = |valid_vec;
  assign lookup_slot_o = slots_q[lookup_tag_i];

  // Slot state: flush empties the table; alloc and free never target the same slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) slots_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) slots_q[i] <= '0;
    end else begin
      if (free_i) slots_q[free_tag_i].valid <= 1'b0;
      if (alloc_i) begin
        slots_q[alloc_tag_o] <= '{valid: 1'b1, fp_wr: alloc_fp_wr_i,
                                   int_wr: alloc_int_wr_i, rd: alloc_rd_i};
      end
    end
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue/completion controller between the FP decoder and a tagged, out-of-order
// FPU. Tracks pending FP destinations for RAW/WAW stalls, routes results to the
// FP regfile or a one-entry integer writeback buffer, and accumulates fflags.
module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int  FLEN         = 32,
  parameter int  NUM_FREGS    = 32,
  parameter int  MAX_INFLIGHT = 4,
  localparam int TAG_W        = $clog2(MAX_INFLIGHT)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [2:0]             issue_rs_used_i,
  input  logic [2:0][REG_AW-1:0] issue_frs_i,
  input  logic                   issue_fp_wr_i,
  input  logic                   issue_int_wr_i,
  input  logic [REG_AW-1:0]      issue_rd_i,
  output logic                   fpu_in_valid_o,
  input  logic                   fpu_in_ready_i,
  output logic [TAG_W-1:0]       fpu_tag_o,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic [TAG_W-1:0]       fpu_tag_i,
  input  logic [FLEN-1:0]        fpu_result_i,
  input  logic [FLAG_W-1:0]      fpu_status_i,
  output logic                   fpu_flush_o,
  output logic                   fp_wb_en_o,
  output logic [REG_AW-1:0]      fp_wb_addr_o,
  output logic [FLEN-1:0]        fp_wb_data_o,
  output logic                   int_wb_valid_o,
  input  logic                   int_wb_ready_i,
  output logic [REG_AW-1:0]      int_wb_addr_o,
  output logic [31:0]            int_wb_data_o,
  input  logic                   flush_i,
  input  logic                   fflags_clr_i,
  output logic [FLAG_W-1:0]      fflags_o,
  output logic                   busy_o
);

  logic [NUM_FREGS-1:0] pend_q, pend_d;
  fflags_t              fflags_q, fflags_d;
  logic                 int_full_q;
  logic [REG_AW-1:0]    int_addr_q;
  logic [31:0]          int_data_q;
  logic [31:0]          int_res;

  slot_t                cpl_slot;
  logic                 table_full, any_valid;
  logic                 hazard, can_issue, fire;
  logic                 cpl_hs, cpl_ok, fp_cpl, int_load;

  fp_tag_table #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_tag_table (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .alloc_i        (fire),
    .alloc_fp_wr_i  (issue_fp_wr_i),
    .alloc_int_wr_i (issue_int_wr_i),
    .alloc_rd_i     (issue_rd_i),
    .free_i         (cpl_ok),
    .free_tag_i     (fpu_tag_i),
    .lookup_tag_i   (fpu_tag_i),
    .lookup_slot_o  (cpl_slot),
    .alloc_tag_o    (fpu_tag_o),
    .full_o         (table_full),
    .any_valid_o    (any_valid)
  );

  // RAW on any FP source or WAW on the FP destination, from registered pend bits only.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (issue_rs_used_i[k] && pend_q[issue_frs_i[k]]) hazard = 1'b1;
    end
    if (issue_fp_wr_i && pend_q[issue_rd_i]) hazard = 1'b1;
  end

  assign can_issue      = issue_valid_i & ~hazard & ~table_full & ~flush_i;
  assign fpu_in_valid_o = can_issue;
  assign fire           = can_issue & fpu_in_ready_i;
  assign issue_ready_o  = fire;
  assign fpu_flush_o    = flush_i;

  // Result acceptance; a full int buffer still accepts when it drains this cycle.
  assign fpu_out_ready_o = ~int_full_q | int_wb_ready_i;
  assign cpl_hs          = fpu_out_valid_i & fpu_out_ready_o;
  assign cpl_ok          = cpl_hs & cpl_slot.valid & ~flush_i;
  assign fp_cpl          = cpl_ok & cpl_slot.fp_wr;
  assign int_load        = cpl_ok & cpl_slot.int_wr;

  assign fp_wb_en_o   = fp_cpl;
  assign fp_wb_addr_o = fp_cpl ? cpl_slot.rd : '0;
  assign fp_wb_data_o = fp_cpl ? fpu_result_i : '0;

  if (FLEN >= 32) begin : gen_int_trunc
    assign int_res = fpu_result_i[31:0];
  end else begin : gen_int_zext
    assign int_res = {{(32 - FLEN){1'b0}}, fpu_result_i};
  end

  // Next pend bits: set on FP-writing issue, cleared on FP writeback; WAW stall keeps them disjoint.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (fp_cpl) pend_d[cpl_slot.rd] = 1'b0;
      if (fire && issue_fp_wr_i) pend_d[issue_rd_i] = 1'b1;
    end
  end

  // Next flag state: only completions of live slots contribute.
  always_comb begin
    fflags_d = fflags_merge(fflags_q, fpu_status_i, cpl_ok, fflags_clr_i);
  end

  // Scoreboard and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      fflags_q <= '0;
    end else begin
      pend_q   <= pend_d;
      fflags_q <= fflags_d;
    end
  end

  // One-entry integer writeback buffer, held until the integer side takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_full_q <= 1'b0;
      int_addr_q <= '0;
      int_data_q <= '0;
    end else if (flush_i) begin
      int_full_q <= 1'b0;
    end else if (int_load) begin
      int_full_q <= 1'b1;
      int_addr_q <= cpl_slot.rd;
      int_data_q <= int_res;
    end else if (int_wb_ready_i) begin
      int_full_q <= 1'b0;
    end
  end

  assign int_wb_valid_o = int_full_q;
  assign int_wb_addr_o  = int_addr_q;
  assign int_wb_data_o  = int_data_q;
  assign fflags_o       = fflags_q;
  assign busy_o         = any_valid | int_full_q;

endmodule
